// File: rtl/mont_mul_radix2.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// Takes WIDTH+2 cycles from start to start; start is ignored while busy.
module mont_mul_radix2 #(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOOP, SUB} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] m_reg;
    logic [WIDTH+1:0] c_reg;
    logic [CW-1:0]    iter;

    logic             accept;
    logic [WIDTH+1:0] t_add;
    logic [WIDTH+1:0] t_red;
    logic [WIDTH-1:0] c_sub;
    logic             c_ge_m;

    assign accept = resetn && (state == IDLE) && start;

    // C < 2M and B < M keep T + M below 4M, so WIDTH+2 bits never overflow.
    always_comb begin
        t_add  = c_reg + (a_sh[0] ? {2'b00, b_reg} : '0);
        t_red  = t_add[0] ? (t_add + {2'b00, m_reg}) : t_add;
        c_sub  = c_reg[WIDTH-1:0] - m_reg;
        c_ge_m = (c_reg >= {2'b00, m_reg});
    end

    // Operand copies carry no reset: they are always reloaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh  <= in_a;
            b_reg <= in_b;
            m_reg <= in_m;
        end else if (state == LOOP) begin
            a_sh <= a_sh >> 1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= IDLE;
            c_reg  <= '0;
            iter   <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        c_reg <= '0;
                        iter  <= '0;
                        busy  <= 1'b1;
                        state <= LOOP;
                    end
                end
                LOOP: begin
                    c_reg <= t_red >> 1;
                    iter  <= iter + CW'(1);
                    if (iter == CW'(WIDTH - 1)) begin
                        state <= SUB;
                    end
                end
                SUB: begin
                    result <= c_ge_m ? c_sub : c_reg[WIDTH-1:0];
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mont_mul_radix2.sv
// Bench for mont_mul_radix2 at WIDTH=8 (vectors, corner sequences, random) and WIDTH=1024 (chained).
module tb_mont_mul_radix2;

    localparam int WW        = 1024;
    localparam int CHAIN_LEN = 60;

    logic          clk;
    logic          rst8_n;
    logic          start8;
    logic [7:0]    a8, b8, m8;
    logic [7:0]    res8;
    logic          done8, busy8;

    logic          rstw_n;
    logic          startw;
    logic [WW-1:0] aw, bw, mw;
    logic [WW-1:0] resw;
    logic          donew, busyw;

    int n_checks = 0;
    int n_pass   = 0;

    mont_mul_radix2 #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .resetn (rst8_n),
        .start  (start8),
        .in_a   (a8),
        .in_b   (b8),
        .in_m   (m8),
        .result (res8),
        .done   (done8),
        .busy   (busy8)
    );

    mont_mul_radix2 #(.WIDTH(WW)) u_dutw (
        .clk    (clk),
        .resetn (rstw_n),
        .start  (startw),
        .in_a   (aw),
        .in_b   (bw),
        .in_m   (mw),
        .result (resw),
        .done   (donew),
        .busy   (busyw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act[191:0], exp[191:0]);
    endtask

    // Reference: the unique R < M with R*2^8 == A*B (mod M), found by search.
    function automatic logic [7:0] ref8(input int a, input int b, input int m);
        int t;
        t = (a * b) % m;
        for (int r = 0; r < m; r++) begin
            if (((r * 256) % m) == t) return r[7:0];
        end
        return 8'd0;
    endfunction

    // Reference: (A*B mod M) multiplied by the inverse of 2, WW times.
    function automatic logic [WW-1:0] refw(input logic [WW-1:0] a, input logic [WW-1:0] b,
                                           input logic [WW-1:0] m);
        logic [2*WW-1:0] p;
        logic [WW:0]     x;
        p = {{WW{1'b0}}, a} * {{WW{1'b0}}, b};
        x = (WW+1)'(p % {{WW{1'b0}}, m});
        for (int k = 0; k < WW; k++) begin
            x = x[0] ? ((x + {1'b0, m}) >> 1) : (x >> 1);
        end
        return x[WW-1:0];
    endfunction

    // Called just after a rising edge with the DUT idle; returns with done sampled high.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        output logic [7:0] res, output int edges, output int busy_n, output bit ok);
        a8 = a; b8 = b; m8 = m; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        edges = 1; busy_n = 0; ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (done8) begin ok = 1'b1; break; end
            busy_n += int'(busy8);
            @(posedge clk); #1;
            edges++;
        end
        res = res8;
    endtask

    task automatic runw(input logic [WW-1:0] a, input logic [WW-1:0] b,
                        output logic [WW-1:0] res, output int edges, output bit ok);
        aw = a; bw = b; startw = 1'b1;
        @(posedge clk); #1;
        startw = 1'b0;
        edges = 1; ok = 1'b0;
        for (int n = 0; n < WW + 40; n++) begin
            if (donew) begin ok = 1'b1; break; end
            @(posedge clk); #1;
            edges++;
        end
        res = resw;
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] m;
        logic [7:0] exp;
    } vec_t;

    initial begin
        vec_t          tbl[4];
        logic [7:0]    r8;
        int            edges, busy_n, dcnt, last, bad, e;
        bit            ok, seen;
        logic [WW-1:0] mod_w, tmp, ra, rb, rres, rexp;

        tbl[0] = '{a: 8'd5,   b: 8'd7,   m: 8'd13,  exp: 8'd1};
        tbl[1] = '{a: 8'd254, b: 8'd254, m: 8'd255, exp: 8'd1};
        tbl[2] = '{a: 8'd1,   b: 8'd1,   m: 8'd13,  exp: 8'd3};
        tbl[3] = '{a: 8'd0,   b: 8'd200, m: 8'd251, exp: 8'd0};

        rst8_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; m8 = '0;
        rstw_n = 1'b0; startw = 1'b0; aw = '0; bw = '0; mw = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result8", res8, 0);
        chk("reset done8", done8, 0);
        chk("reset busy8", busy8, 0);
        chk("reset resultw", resw, 0);
        chk("reset busyw", busyw, 0);
        rst8_n = 1'b1; rstw_n = 1'b1;
        @(posedge clk); #1;

        // Fixed vectors: value, latency, busy length, single-cycle done.
        foreach (tbl[i]) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].m, r8, edges, busy_n, ok);
            chk($sformatf("vec%0d done seen", i), ok, 1);
            chk($sformatf("vec%0d result", i), r8, tbl[i].exp);
            chk($sformatf("vec%0d latency", i), edges, 10);
            chk($sformatf("vec%0d busy cycles", i), busy_n, 9);
            @(posedge clk); #1;
            chk($sformatf("vec%0d done one cycle", i), done8, 0);
        end

        // Random odd moduli, operands below M.
        for (int i = 0; i < 30; i++) begin
            logic [7:0] rm, ra8, rb8;
            rm  = 8'($urandom_range(1, 127) * 2 + 1);
            ra8 = 8'($urandom % rm);
            rb8 = 8'($urandom % rm);
            run8(ra8, rb8, rm, r8, edges, busy_n, ok);
            chk($sformatf("rand%0d done seen", i), ok, 1);
            chk($sformatf("rand%0d result a=%0d b=%0d m=%0d", i, ra8, rb8, rm), r8, ref8(ra8, rb8, rm));
        end

        // Start held high: back-to-back operations every 10 cycles.
        a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; start8 = 1'b1;
        dcnt = 0; last = -5; bad = 0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done8) begin
                chk($sformatf("held result @%0d", n), res8, 1);
                chk($sformatf("held period @%0d", n), n % 10, 0);
                if (last == n - 1) bad++;
                dcnt++;
                last = n;
            end
        end
        start8 = 1'b0;
        chk("held done count", dcnt, 3);
        chk("held no consecutive done", bad, 0);
        @(posedge clk); #1;

        // Reset during LOOP iteration 4, with start asserted while in reset.
        a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst8_n = 1'b0; start8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst8_n = 1'b1; start8 = 1'b0;
        chk("abort result cleared", res8, 0);
        chk("abort busy low", busy8, 0);
        dcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            dcnt += int'(done8) + int'(busy8);
        end
        chk("abort no done or busy", dcnt, 0);
        run8(8'd1, 8'd1, 8'd13, r8, edges, busy_n, ok);
        chk("post-reset done seen", ok, 1);
        chk("post-reset result", r8, 3);
        chk("post-reset latency", edges, 10);
        @(posedge clk); #1;

        // Restart attempt with new operands during LOOP must be ignored.
        a8 = 8'd5; b8 = 8'd7; m8 = 8'd13; start8 = 1'b1;
        seen = 1'b0; e = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(posedge clk); #1;
            if (n == 1) start8 = 1'b0;
            if (n == 3) begin a8 = 8'd200; b8 = 8'd3; m8 = 8'd251; start8 = 1'b1; end
            if (n == 6) start8 = 1'b0;
            if (done8) begin seen = 1'b1; e = n; end
        end
        chk("restart done seen", seen, 1);
        chk("restart latency", e, 10);
        chk("restart result", res8, 1);
        dcnt = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            dcnt += int'(done8) + int'(busy8);
        end
        chk("restart not queued", dcnt, 0);
        chk("restart result held", res8, 1);

        // Wide operation: A=B=1 gives 2^-1024 mod M, then a dependent chain.
        for (int i = 0; i < WW / 32; i++) tmp[i*32 +: 32] = $urandom;
        mod_w = tmp;
        mod_w[WW-1 -: 24] = 24'hfb7348;
        mod_w[19:0]       = 20'hef519;
        mw = mod_w;
        ra = 1; rb = 1;
        rexp = refw(ra, rb, mod_w);
        runw(ra, rb, rres, edges, ok);
        chk("wide done seen", ok, 1);
        chk("wide 2^-1024 mod M", rres, rexp);
        chk("wide latency", edges, WW + 2);
        for (int it = 0; it < CHAIN_LEN; it++) begin
            ra = rb ^ rres;
            rb = rres;
            rexp = refw(ra, rb, mod_w);
            runw(ra, rb, rres, edges, ok);
            chk($sformatf("chain%0d done seen", it), ok, 1);
            chk($sformatf("chain%0d result", it), rres, rexp);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
